// File: rtl/irq_arbiter.sv
// Interrupt arbiter: captures edge/level requests, masks them, picks one winner
// (fixed or round-robin) and holds it towards the core until the mret completion pulse.
module irq_arbiter #(
  parameter int N_SRC = 32,
  parameter int RR    = 0,
  parameter int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_SRC-1:0] int_req_i,
  input  logic [N_SRC-1:0] edge_mode_i,
  input  logic [N_SRC-1:0] mie_i,
  input  logic             int_rst_i,
  output logic             irq_o,
  output logic [31:0]      mcause_o,
  output logic [N_SRC-1:0] int_fin_o,
  output logic [N_SRC-1:0] pending_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [N_SRC-1:0]  pend_q, pend_d;
  logic [N_SRC-1:0]  req_q, req_d;
  logic [N_SRC-1:0]  fin_q, fin_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              irq_q, irq_d;

  logic [N_SRC-1:0]  elig;
  logic [N_SRC-1:0]  rise;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   hi_win, lo_win;
  logic              hi_found;

  assign elig = ((pend_q & edge_mode_i) | (int_req_i & ~edge_mode_i)) & mie_i;
  assign rise = int_req_i & ~req_q & edge_mode_i;

  // Scanning downwards leaves the lowest qualifying index; the "hi" candidate only
  // accepts indices at or above the round-robin pointer, "lo" is the wrap-around fallback.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    hi_win   = '0;
    lo_win   = '0;
    hi_found = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        lo_win = ID_W'(i);
        if (RR == 0 || i >= int'(rr_ptr_q)) begin
          hi_win   = ID_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    winner = hi_found ? hi_win : lo_win;
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    fin_d    = '0;
    req_d    = int_req_i;

    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d = ACTIVE;
          id_d    = winner;
        end
      end
      ACTIVE: begin
        if (int_rst_i) begin
          state_d = IDLE;
          for (int i = 0; i < N_SRC; i++) begin
            fin_d[i] = (int'(id_q) == i);
          end
          if (RR != 0) begin
            rr_ptr_d = (int'(id_q) == N_SRC - 1) ? '0 : id_q + ID_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A rising edge landing on the retired source outranks the clear.
    pend_d = ((pend_q & ~fin_d) | rise) & edge_mode_i;
    irq_d  = (state_d == ACTIVE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      req_q    <= '0;
      fin_q    <= '0;
      id_q     <= '0;
      rr_ptr_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      req_q    <= req_d;
      fin_q    <= fin_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_o     = irq_q;
  assign mcause_o  = {{(32 - ID_W){1'b0}}, id_q};
  assign int_fin_o = fin_q;
  assign pending_o = pend_q | (int_req_i & ~edge_mode_i);

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: three instances (fixed, round-robin, single source) checked
// every cycle against a behavioural model, plus directed literal scenarios.
module tb_irq_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] req   = '0;
  logic [31:0] edge_m = '0;
  logic [31:0] mie   = '0;
  logic        int_rst = 1'b0;

  logic        irq_fp, irq_rr, irq_n1;
  logic [31:0] mcause_fp, mcause_rr, mcause_n1;
  logic [31:0] fin_fp, fin_rr, pend_fp, pend_rr;
  logic [0:0]  fin_n1, pend_n1;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk_i = ~clk_i;

  irq_arbiter #(.N_SRC(32), .RR(0)) dut_fp (
    .clk_i(clk_i), .rst_i(rst_i), .int_req_i(req), .edge_mode_i(edge_m), .mie_i(mie),
    .int_rst_i(int_rst), .irq_o(irq_fp), .mcause_o(mcause_fp), .int_fin_o(fin_fp),
    .pending_o(pend_fp));

  irq_arbiter #(.N_SRC(32), .RR(1)) dut_rr (
    .clk_i(clk_i), .rst_i(rst_i), .int_req_i(req), .edge_mode_i(edge_m), .mie_i(mie),
    .int_rst_i(int_rst), .irq_o(irq_rr), .mcause_o(mcause_rr), .int_fin_o(fin_rr),
    .pending_o(pend_rr));

  irq_arbiter #(.N_SRC(1), .RR(0)) dut_n1 (
    .clk_i(clk_i), .rst_i(rst_i), .int_req_i(req[0:0]), .edge_mode_i(edge_m[0:0]),
    .mie_i(mie[0:0]), .int_rst_i(int_rst), .irq_o(irq_n1), .mcause_o(mcause_n1),
    .int_fin_o(fin_n1), .pending_o(pend_n1));

  logic        d_irq    [3];
  logic [31:0] d_mcause [3];
  logic [31:0] d_fin    [3];
  logic [31:0] d_pend   [3];

  assign d_irq[0] = irq_fp;  assign d_mcause[0] = mcause_fp;
  assign d_irq[1] = irq_rr;  assign d_mcause[1] = mcause_rr;
  assign d_irq[2] = irq_n1;  assign d_mcause[2] = mcause_n1;
  assign d_fin[0] = fin_fp;  assign d_pend[0] = pend_fp;
  assign d_fin[1] = fin_rr;  assign d_pend[1] = pend_rr;
  assign d_fin[2] = {31'b0, fin_n1};
  assign d_pend[2] = {31'b0, pend_n1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one entry per instance.
  int          n_src [3] = '{32, 32, 1};
  bit          rr_m  [3] = '{1'b0, 1'b1, 1'b0};
  bit          m_active [3];
  int          m_id  [3];
  int          m_ptr [3];
  bit [31:0]   m_pend [3];
  bit [31:0]   m_prev [3];
  bit [31:0]   m_fin  [3];
  bit [31:0]   t_m, t_r, t_e, t_en, t_elig, t_clr;

  function automatic bit [31:0] in_mask(input int n);
    return (n == 32) ? 32'hFFFF_FFFF : 32'h1;
  endfunction

  // First eligible index at or after start, wrapping around the source count.
  function automatic int pick(input bit [31:0] el, input int start, input int n);
    for (int k = 0; k < n; k++) begin
      int j;
      j = (start + k) % n;
      if (el[j]) return j;
    end
    return 0;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    for (int d = 0; d < 3; d++) begin
      if (rst_i) begin
        m_active[d] = 1'b0; m_id[d] = 0; m_ptr[d] = 0;
        m_pend[d] = '0; m_prev[d] = '0; m_fin[d] = '0;
      end else begin
        t_m    = in_mask(n_src[d]);
        t_r    = req & t_m;
        t_e    = edge_m & t_m;
        t_en   = mie & t_m;
        t_elig = ((m_pend[d] & t_e) | (t_r & ~t_e)) & t_en;
        t_clr  = '0;
        if (!m_active[d]) begin
          if (t_elig != 0) begin
            m_active[d] = 1'b1;
            m_id[d]     = pick(t_elig, rr_m[d] ? m_ptr[d] : 0, n_src[d]);
          end
        end else if (int_rst) begin
          m_active[d] = 1'b0;
          t_clr       = 32'h1 << m_id[d];
          if (rr_m[d]) m_ptr[d] = (m_id[d] + 1) % n_src[d];
        end
        m_fin[d]  = t_clr;
        m_pend[d] = ((m_pend[d] & ~t_clr) | (t_r & ~m_prev[d] & t_e)) & t_e;
        m_prev[d] = t_r;
      end
    end
  end

  always @(negedge clk_i) begin
    if (cmp_en) begin
      for (int d = 0; d < 3; d++) begin
        check($sformatf("cmp_irq_d%0d", d), {31'b0, d_irq[d]}, {31'b0, m_active[d]});
        check($sformatf("cmp_mcause_d%0d", d), d_mcause[d], 32'(m_id[d]));
        check($sformatf("cmp_fin_d%0d", d), d_fin[d], m_fin[d]);
        check($sformatf("cmp_pending_d%0d", d), d_pend[d],
              (m_pend[d] | (req & ~edge_m)) & in_mask(n_src[d]));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic retire();
    int_rst = 1'b1;
    tick();
    int_rst = 1'b0;
  endtask

  int exp_rr [4] = '{2, 7, 30, 2};

  initial begin
    do_reset();
    cmp_en = 1'b1;
    check("reset_irq", {31'b0, irq_fp}, 32'h0);
    check("reset_mcause", mcause_fp, 32'h0);
    check("reset_fin", fin_fp, 32'h0);
    check("reset_pending", pend_fp, 32'h0);

    // Level source 5: one-cycle latency, re-served after one IDLE cycle.
    mie = 32'h20; req = 32'h20;
    tick();
    check("lvl5_irq", {31'b0, irq_fp}, 32'h1);
    check("lvl5_mcause", mcause_fp, 32'd5);
    retire();
    check("lvl5_fin_irq", {31'b0, irq_fp}, 32'h0);
    check("lvl5_fin", fin_fp, 32'h20);
    check("lvl5_fin_mcause", mcause_fp, 32'd5);
    tick();
    check("lvl5_reserve_irq", {31'b0, irq_fp}, 32'h1);
    check("lvl5_reserve_fin", fin_fp, 32'h0);
    check("lvl5_reserve_mcause", mcause_fp, 32'd5);
    req = '0;
    retire();
    tick();

    // Edge source 3: two-cycle latency, nothing pending after completion.
    edge_m = 32'h8; mie = 32'h8; req = 32'h8;
    tick();
    req = '0;
    check("edge3_e0_irq", {31'b0, irq_fp}, 32'h0);
    check("edge3_e0_pending", pend_fp, 32'h8);
    tick();
    check("edge3_irq", {31'b0, irq_fp}, 32'h1);
    check("edge3_mcause", mcause_fp, 32'd3);
    retire();
    check("edge3_fin", fin_fp, 32'h8);
    check("edge3_pending", pend_fp, 32'h0);
    tick();
    check("edge3_idle_irq", {31'b0, irq_fp}, 32'h0);

    // Sources 2, 7, 30 level-high: fixed always picks 2, round-robin rotates.
    rst_i = 1'b1;
    edge_m = '0; mie = 32'hFFFF_FFFF; req = 32'h4000_0084;
    tick();
    rst_i = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("arb_fp_mcause_%0d", k), mcause_fp, 32'd2);
      check($sformatf("arb_rr_mcause_%0d", k), mcause_rr, 32'(exp_rr[k]));
      retire();
      check($sformatf("arb_fp_fin_%0d", k), fin_fp, 32'h4);
      check($sformatf("arb_rr_fin_%0d", k), fin_rr, 32'h1 << exp_rr[k]);
      tick();
    end

    // Source 4 in service: masking and dropping the request do not disturb it.
    rst_i = 1'b1;
    edge_m = '0; mie = 32'h10; req = 32'h10;
    tick();
    rst_i = 1'b0;
    tick();
    check("hold4_mcause", mcause_fp, 32'd4);
    mie = '0; req = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("hold4_irq_%0d", k), {31'b0, irq_fp}, 32'h1);
      check($sformatf("hold4_mcause_%0d", k), mcause_fp, 32'd4);
    end
    retire();
    check("hold4_fin", fin_fp, 32'h10);
    tick();
    retire();
    check("idle_rst_fin", fin_fp, 32'h0);
    check("idle_rst_irq", {31'b0, irq_fp}, 32'h0);

    // Edge source 6 re-pulses while being retired: the new edge survives.
    do_reset();
    edge_m = 32'h40; mie = 32'h40; req = 32'h40;
    tick();
    req = '0;
    tick();
    check("edge6_mcause", mcause_fp, 32'd6);
    req = 32'h40; int_rst = 1'b1;
    tick();
    req = '0; int_rst = 1'b0;
    check("edge6_fin", fin_fp, 32'h40);
    check("edge6_pending", pend_fp, 32'h40);
    check("edge6_gap_irq", {31'b0, irq_fp}, 32'h0);
    tick();
    check("edge6_reserve_irq", {31'b0, irq_fp}, 32'h1);
    check("edge6_reserve_mcause", mcause_fp, 32'd6);
    retire();
    check("edge6_done_pending", pend_fp, 32'h0);

    // Asynchronous reset while active.
    do_reset();
    edge_m = 32'h2; mie = 32'hFFFF_FFFF; req = 32'h3;
    tick();
    check("arst_pre_irq", {31'b0, irq_fp}, 32'h1);
    check("arst_pre_pending", pend_fp, 32'h3);
    check("n1_irq", {31'b0, irq_n1}, 32'h1);
    check("n1_mcause", mcause_n1, 32'h0);
    #1;
    rst_i = 1'b1;
    req = '0;
    #1;
    check("arst_irq", {31'b0, irq_fp}, 32'h0);
    check("arst_mcause", mcause_fp, 32'h0);
    check("arst_fin", fin_fp, 32'h0);
    check("arst_pending", pend_fp, 32'h0);
    check("arst_n1_irq", {31'b0, irq_n1}, 32'h0);
    tick();
    rst_i = 1'b0;
    tick();
    check("arst_after_fin", fin_fp, 32'h0);
    check("arst_after_irq", {31'b0, irq_fp}, 32'h0);

    // Randomised traffic, including occasional mid-cycle resets.
    edge_m = $urandom; mie = $urandom | $urandom;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk_i);
      #2;
      rst_i   = 1'b0;
      req     = $urandom & $urandom & $urandom;
      int_rst = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) edge_m = $urandom;
      if ($urandom_range(0, 7) == 0) mie = $urandom | $urandom;
      if ($urandom_range(0, 249) == 0) begin
        #1;
        rst_i = 1'b1;
      end
    end
    tick();
    rst_i = 1'b0;
    int_rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
